// File: rtl/opsum_writeback_pkg.sv
// rtl/opsum_writeback_pkg.sv - shared types and constants for the opsum drain path
// Purpose: word size, FSM state encoding and the latched tile configuration
//          record used by opsum_writeback and its address generator.
package opsum_writeback_pkg;

    localparam int WORD_BYTES     = 4;
    localparam int WORD_SHIFT     = 2;
    localparam int CFG_ADDR_WIDTH = 32;
    localparam int CFG_DIM_WIDTH  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wb_state_e;

    typedef struct packed {
        logic                      relu_en;
        logic [CFG_DIM_WIDTH-1:0]  tile_m;
        logic [CFG_DIM_WIDTH-1:0]  tile_e;
        logic [CFG_DIM_WIDTH-1:0]  tile_f;
        logic [CFG_ADDR_WIDTH-1:0] row_stride;
        logic [CFG_ADDR_WIDTH-1:0] plane_stride;
    } wb_cfg_t;

endpackage

// File: rtl/wb_addr_gen.sv
// rtl/wb_addr_gen.sv - nested m/e/f counters with GLB and DRAM address pointers
// Purpose: walks the tile f-innermost, producing a linear GLB address and a
//          strided DRAM address without any multiplier.
// Ports:   clk_i, rst_i      clock, synchronous active-high reset
//          init_i            load base/origin and clear counters
//          step_i            advance to the next word
//          glb_base_i, dram_origin_i, row_stride_i, plane_stride_i  addressing
//          tile_m_i, tile_e_i, tile_f_i                             extents
//          glb_addr_o, dram_addr_o   addresses of the current word
//          last_o            current word is the final word of the tile
module wb_addr_gen
    import opsum_writeback_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DIM_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  init_i,
    input  logic                  step_i,
    input  logic [ADDR_WIDTH-1:0] glb_base_i,
    input  logic [ADDR_WIDTH-1:0] dram_origin_i,
    input  logic [ADDR_WIDTH-1:0] row_stride_i,
    input  logic [ADDR_WIDTH-1:0] plane_stride_i,
    input  logic [DIM_WIDTH-1:0]  tile_m_i,
    input  logic [DIM_WIDTH-1:0]  tile_e_i,
    input  logic [DIM_WIDTH-1:0]  tile_f_i,
    output logic [ADDR_WIDTH-1:0] glb_addr_o,
    output logic [ADDR_WIDTH-1:0] dram_addr_o,
    output logic                  last_o
);

    logic [DIM_WIDTH-1:0]  f_q, f_d, e_q, e_d, m_q, m_d;
    logic [ADDR_WIDTH-1:0] row_q, row_d, plane_q, plane_d, glb_q, glb_d;
    logic                  f_last, e_last, m_last;

    assign f_last = (f_q + DIM_WIDTH'(1)) == tile_f_i;
    assign e_last = (e_q + DIM_WIDTH'(1)) == tile_e_i;
    assign m_last = (m_q + DIM_WIDTH'(1)) == tile_m_i;

    assign last_o      = f_last && e_last && m_last;
    assign glb_addr_o  = glb_q;
    assign dram_addr_o = row_q + (ADDR_WIDTH'(f_q) << WORD_SHIFT);

    always_comb begin
        f_d     = f_q;
        e_d     = e_q;
        m_d     = m_q;
        row_d   = row_q;
        plane_d = plane_q;
        glb_d   = glb_q;
        if (init_i) begin
            f_d     = '0;
            e_d     = '0;
            m_d     = '0;
            row_d   = dram_origin_i;
            plane_d = dram_origin_i;
            glb_d   = glb_base_i;
        end else if (step_i) begin
            glb_d = glb_q + ADDR_WIDTH'(WORD_BYTES);
            if (f_last) begin
                f_d = '0;
                if (e_last) begin
                    // New channel: both pointers jump to the next plane origin.
                    e_d     = '0;
                    m_d     = m_q + DIM_WIDTH'(1);
                    plane_d = plane_q + plane_stride_i;
                    row_d   = plane_q + plane_stride_i;
                end else begin
                    e_d   = e_q + DIM_WIDTH'(1);
                    row_d = row_q + row_stride_i;
                end
            end else begin
                f_d = f_q + DIM_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            f_q     <= '0;
            e_q     <= '0;
            m_q     <= '0;
            row_q   <= '0;
            plane_q <= '0;
            glb_q   <= '0;
        end else begin
            f_q     <= f_d;
            e_q     <= e_d;
            m_q     <= m_d;
            row_q   <= row_d;
            plane_q <= plane_d;
            glb_q   <= glb_d;
        end
    end

endmodule

// File: rtl/opsum_writeback.sv
// rtl/opsum_writeback.sv - drains one opsum tile from GLB into strided DRAM
// Purpose: on start, reads the contiguous [m][e][f] GLB tile one word per
//          cycle and writes it to DRAM at row/plane pitches, optional ReLU.
// Ports:   clk, rst, start, finish, busy, relu_en          control
//          tile_m/e/f, glb_opsum_base_addr, dram_tile_addr,
//          dram_row_stride, dram_plane_stride              tile config
//          glb_r_addr, glb_r_data                          GLB read port
//          dram_we, dram_addr, dram_w_data                 DRAM write port
module opsum_writeback
    import opsum_writeback_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8,
    parameter int DIM_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    finish,
    output logic                    busy,
    input  logic                    relu_en,
    input  logic [DIM_WIDTH-1:0]    tile_m,
    input  logic [DIM_WIDTH-1:0]    tile_e,
    input  logic [DIM_WIDTH-1:0]    tile_f,
    input  logic [ADDR_WIDTH-1:0]   glb_opsum_base_addr,
    input  logic [ADDR_WIDTH-1:0]   dram_tile_addr,
    input  logic [ADDR_WIDTH-1:0]   dram_row_stride,
    input  logic [ADDR_WIDTH-1:0]   dram_plane_stride,
    output logic [ADDR_WIDTH-1:0]   glb_r_addr,
    input  logic [4*DATA_WIDTH-1:0] glb_r_data,
    output logic                    dram_we,
    output logic [ADDR_WIDTH-1:0]   dram_addr,
    output logic [4*DATA_WIDTH-1:0] dram_w_data
);

    wb_state_e             state_q, state_d;
    wb_cfg_t               cfg_q, cfg_d;
    logic                  empty_q, empty_d;
    logic                  dram_we_q;
    logic [ADDR_WIDTH-1:0] dram_addr_q;
    logic [ADDR_WIDTH-1:0] gen_dram_addr;
    logic                  gen_last;
    logic                  accept, dims_zero, in_run;

    assign accept    = (state_q == IDLE) && start;
    assign dims_zero = (tile_m == '0) || (tile_e == '0) || (tile_f == '0);
    assign in_run    = (state_q == RUN);

    wb_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DIM_WIDTH  (DIM_WIDTH)
    ) u_addr_gen (
        .clk_i          (clk),
        .rst_i          (rst),
        .init_i         (accept),
        .step_i         (in_run),
        .glb_base_i     (glb_opsum_base_addr),
        .dram_origin_i  (dram_tile_addr),
        .row_stride_i   (cfg_q.row_stride),
        .plane_stride_i (cfg_q.plane_stride),
        .tile_m_i       (cfg_q.tile_m),
        .tile_e_i       (cfg_q.tile_e),
        .tile_f_i       (cfg_q.tile_f),
        .glb_addr_o     (glb_r_addr),
        .dram_addr_o    (gen_dram_addr),
        .last_o         (gen_last)
    );

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        empty_d = empty_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cfg_d.relu_en      = relu_en;
                    cfg_d.tile_m       = tile_m;
                    cfg_d.tile_e       = tile_e;
                    cfg_d.tile_f       = tile_f;
                    cfg_d.row_stride   = dram_row_stride;
                    cfg_d.plane_stride = dram_plane_stride;
                    empty_d            = dims_zero;
                    state_d            = dims_zero ? DONE : RUN;
                end
            end
            RUN:   if (gen_last) state_d = DRAIN;
            DRAIN: state_d = DONE;
            // An empty tile idles one cycle in DONE so finish keeps the
            // same start-to-finish latency of N+2 as a populated tile.
            DONE: begin
                if (empty_q) empty_d = 1'b0;
                else         state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cfg_q       <= '0;
            empty_q     <= 1'b0;
            dram_we_q   <= 1'b0;
            dram_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            empty_q   <= empty_d;
            // Write side trails the read by one cycle to match GLB latency.
            dram_we_q <= in_run;
            if (in_run) dram_addr_q <= gen_dram_addr;
        end
    end

    assign busy        = (state_q == RUN) || (state_q == DRAIN);
    assign finish      = (state_q == DONE) && !empty_q;
    assign dram_we     = dram_we_q;
    assign dram_addr   = dram_addr_q;
    assign dram_w_data = (cfg_q.relu_en && glb_r_data[4*DATA_WIDTH-1]) ? '0 : glb_r_data;

endmodule

// File: doc/opsum_writeback.md
Name: opsum_writeback

Overview:
- Drain engine for the output path: on start, copies one opsum tile of 32-bit partial sums from GLB back into the full output tensor in DRAM.
- Direction is the reverse of the Tiling loader, which moves DRAM to GLB.
- GLB tile is contiguous, ordered [m][e][f]. DRAM destination is strided by full-tensor row and plane pitches.
- Optional ReLU is applied in-stream. Sustained throughput is one word per cycle. Sits beside Tiling, sequenced by the same controller.

Parameters:
- ADDR_WIDTH, 32, byte-address width of the GLB and DRAM ports.
- DATA_WIDTH, 8, element width. Bus word is 4*DATA_WIDTH bits.
- DIM_WIDTH, 8, width of the tile-dimension inputs.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request. Sampled only in IDLE.
- finish  out  1  one-cycle pulse when the tile is fully written.
- busy  out  1  high from the cycle after an accepted start until finish.
- relu_en  in  1  clamp negative words to 0 before writing.
- tile_m, tile_e, tile_f  in  DIM_WIDTH each  tile extents: channels, rows, columns.
- glb_opsum_base_addr  in  ADDR_WIDTH  GLB byte address of tile word 0.
- dram_tile_addr  in  ADDR_WIDTH  DRAM byte address of the tile origin (m0, e0, f0).
- dram_row_stride  in  ADDR_WIDTH  bytes between output rows, i.e. F_full*4.
- dram_plane_stride  in  ADDR_WIDTH  bytes between output channels, i.e. E_full*F_full*4.
- glb_r_addr  out  ADDR_WIDTH  GLB read byte address.
- glb_r_data  in  4*DATA_WIDTH  GLB read data, valid 1 cycle after the address.
- dram_we  out  1  DRAM write strobe.
- dram_addr  out  ADDR_WIDTH  DRAM write byte address.
- dram_w_data  out  4*DATA_WIDTH  DRAM write data, little-endian word.

Behaviour:
- Reset values:
  - State IDLE.
  - finish, busy and dram_we are 0.
  - glb_r_addr and dram_addr are 0.
  - All counters are 0.
- States:
  - IDLE: start=1 latches all config inputs. If any dim is 0, go to DONE; otherwise go to RUN.
  - RUN: issue one GLB read per cycle. After the last read is issued, go to DRAIN.
  - DRAIN: one cycle for the final write.
  - DONE: finish=1 for one cycle, then IDLE.
- Loop order: f innermost, then e, then m. N = tile_m*tile_e*tile_f words.
- GLB read address of word k = glb_opsum_base_addr + 4k, via an incrementing register.
- DRAM address is computed incrementally with no multiplier:
  - Start at row_ptr = plane_ptr = dram_tile_addr.
  - On f wrap: row_ptr += row_stride.
  - On e wrap: plane_ptr += plane_stride, and row_ptr = new plane_ptr.
  - Address of the current word = row_ptr + 4f.
- Pipeline timing:
  - Read k is issued in cycle S+1+k, where S is the start-sample cycle.
  - dram_we=1 in cycle S+2+k, with dram_addr registered one stage behind the read address.
  - dram_w_data = relu_en && glb_r_data[MSB] ? 0 : glb_r_data. This is combinational from the registered GLB data.
  - finish is in cycle S+N+2. busy is high for cycles S+1 .. S+N+1.
- dram_we is never asserted outside the N write cycles. There are no duplicate writes and no gaps.
- start while busy is ignored; inputs are unaffected.
- Config inputs may change after start is accepted without effect on the current tile.
- Wrap-around: address adds are modulo 2^ADDR_WIDTH. No overflow detection.
- rst mid-operation: the next cycle is IDLE, dram_we=0 and finish=0. A partial tile may remain in DRAM.
- start coincident with rst: rst wins.

Decomposition:
- Shared package (the one shared with Tiling) holds:
  - WORD_BYTES=4.
  - The state enum typedef: IDLE, RUN, DRAIN, DONE.
  - A typedef for the latched config struct.
- One natural sub-module, wb_addr_gen: the three nested counters plus the row/plane pointer arithmetic. It outputs glb_addr, dram_addr, and a last flag.

Test Plan:
- Tile 2x2x2 (m,e,f) with row_stride=64 and plane_stride=1024, dram_tile_addr=12288, GLB words 1..8 at 6144:
  - Expect writes to 12288, 12292, 12352, 12356, 13312, 13316, 13376, 13380 with data 1..8.
  - finish at S+10.
- relu_en=1 with GLB words 0xFFFFFFFE, 5, 0x80000000, 0x7FFFFFFF (tile 1x1x4):
  - DRAM receives 0, 5, 0, 0x7FFFFFFF.
  - With relu_en=0, the same words pass unchanged.
- tile_e=0:
  - finish at S+2.
  - dram_we never asserted; busy low throughout.
- Full 8x16x16 tile, row_stride=64, plane_stride=1024, into a zeroed DRAM:
  - DRAM matches the GLB contents word-for-word (2048 words).
  - Exactly 2048 dram_we cycles.
- start pulsed again at S+3 of a 1x1x8 transfer:
  - The second start is ignored; exactly 8 writes occur.
  - Then a new start after finish runs normally.
- rst asserted at S+4 of a 1x1x16 transfer:
  - dram_we=0 from the next cycle and no finish.
  - A subsequent start completes all 16 writes.
